// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
//   state_t   : arbiter FSM states
//   width_of  : index/counter width for n values, never below 1 bit
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   function automatic int unsigned width_of(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority selector.
// Returns the first asserted request searching last_owner+1, last_owner+2, ...
// modulo NUM_REQ.
//   req        : request vector
//   last_owner : index of the most recent grant holder (priority pointer)
//   any_req    : at least one request is asserted
//   winner     : index of the selected requester (0 when none)
module rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_owner,
   output logic               any_req,
   output logic [IDX_W-1:0]   winner
);

   // Scan from the farthest offset down so the nearest request wins.
   always_comb begin
      int idx;
      idx     = 0;
      any_req = 1'b0;
      winner  = '0;
      for (int off = int'(NUM_REQ); off > 0; off--) begin
         idx = (int'(last_owner) + off) % int'(NUM_REQ);
         if (req[IDX_W'(idx)]) begin
            any_req = 1'b1;
            winner  = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// A grant lasts for a burst that ends on last, at MAX_BURST beats, or when the
// owner drops its request. Re-arbitration happens in the ending cycle so
// back-to-back bursts have no dead cycle.
//   clk, rst   : write-domain clock, synchronous active-high reset
//   req, last  : per-requester request and end-of-burst flag
//   data       : packed beats, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   accept     : one-hot beat-taken strobe (combinational)
//   fifo_full  : FIFO full flag
//   fifo_w_en  : FIFO write enable (combinational)
//   fifo_data  : FIFO data_in (combinational)
//   owner      : current grant holder
//   busy       : high while in BURST
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MAX_BURST  = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ-1:0]              last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   data,
   output logic [NUM_REQ-1:0]              accept,
   input  logic                            fifo_full,
   output logic                            fifo_w_en,
   output logic [DATA_WIDTH-1:0]           fifo_data,
   output logic [width_of(NUM_REQ)-1:0]    owner,
   output logic                            busy
);

   localparam int unsigned IDX_W = width_of(NUM_REQ);
   localparam int unsigned CNT_W = width_of(MAX_BURST);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   owner_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   last_owner_q, last_owner_d;

   logic               own_req_c;
   logic               own_last_c;
   logic               beat_c;
   logic               max_c;
   logic               end_c;
   logic [IDX_W-1:0]   pick_ptr_c;
   logic               any_req_c;
   logic [IDX_W-1:0]   winner_c;

   // During a burst the search starts after the current owner, so the
   // re-arbitration at burst end already sees the updated pointer order.
   assign pick_ptr_c = (state_q == BURST) ? owner : last_owner_q;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req        (req),
      .last_owner (pick_ptr_c),
      .any_req    (any_req_c),
      .winner     (winner_c)
   );

   assign own_req_c  = req[owner];
   assign own_last_c = last[owner];

   // rst gates the beat so an in-flight beat is never written in a reset cycle.
   assign beat_c = (state_q == BURST) && own_req_c && !fifo_full && !rst;
   assign max_c  = (cnt_q == CNT_W'(MAX_BURST - 1));
   assign end_c  = (state_q == BURST) &&
                   ((beat_c && (own_last_c || max_c)) || !own_req_c);

   // Beat strobe and data mux for the owner.
   always_comb begin
      accept    = '0;
      fifo_data = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (beat_c && (owner == IDX_W'(i))) begin
            accept[i] = 1'b1;
            fifo_data = data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign fifo_w_en = beat_c;
   assign busy      = (state_q == BURST);

   // Next-state logic.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner;
      cnt_d        = cnt_q;
      last_owner_d = last_owner_q;
      case (state_q)
         IDLE: begin
            if (any_req_c) begin
               state_d = BURST;
               owner_d = winner_c;
               cnt_d   = '0;
            end
         end
         BURST: begin
            if (end_c) begin
               last_owner_d = owner;
               cnt_d        = '0;
               if (any_req_c) begin
                  owner_d = winner_c;
               end else begin
                  state_d = IDLE;
               end
            end else if (beat_c) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset makes requester 0 highest priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         owner        <= '0;
         cnt_q        <= '0;
         last_owner_q <= IDX_W'(NUM_REQ - 1);
      end else begin
         state_q      <= state_d;
         owner        <= owner_d;
         cnt_q        <= cnt_d;
         last_owner_q <= last_owner_d;
      end
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the write port of the async FIFO among NUM_REQ requesters in the write-clock domain.
- Grants one requester at a time for a burst of beats, ending on a last flag or at MAX_BURST beats.
- Drives the FIFO's w_en and data_in, and honours full, so no beat is ever lost or duplicated.
- Sits directly in front of the FIFO write side; its clock is the FIFO's wclk.

Parameters:
- NUM_REQ, 4: number of requesters; must be at least 2.
- DATA_WIDTH, 8: beat width; must match the FIFO DATA_WIDTH.
- MAX_BURST, 4: maximum beats per grant; must be at least 1.

Ports:
- clk  input  1  write-domain clock (FIFO wclk).
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request; a requester holds it high while it has beats.
- last  input  NUM_REQ  per-requester end-of-burst flag; qualified by accept.
- data  input  NUM_REQ*DATA_WIDTH  packed beats; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- accept  output  NUM_REQ  one-hot beat-taken strobe; the requester advances to its next beat on the following clk.
- fifo_full  input  1  FIFO full flag.
- fifo_w_en  output  1  FIFO write enable.
- fifo_data  output  DATA_WIDTH  FIFO data_in.
- owner  output  $clog2(NUM_REQ)  index of the current grant holder.
- busy  output  1  high while in BURST.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. On rst sampled high, the FSM goes to IDLE, owner=0, beat_cnt=0, and the round-robin pointer last_owner=NUM_REQ-1, so requester 0 has highest priority after reset.
- Output values in reset and IDLE: accept=0, fifo_w_en=0, fifo_data=0, busy=0.
- FSM states: IDLE, BURST.
- Round-robin pick (combinational): the first asserted req searching last_owner+1, last_owner+2, ... modulo NUM_REQ.
- IDLE: if any req is high, register the winner into owner, set beat_cnt=0 and go to BURST. Arbitration latency is 1 cycle: the first beat can be accepted in the cycle after req rises.
- BURST, beat condition: beat = req[owner] && !fifo_full. The following outputs are combinational from registered state and inputs:
  - accept[owner]=beat; all other accept bits are 0.
  - fifo_w_en=beat.
  - fifo_data = data slice of owner when beat, else 0.
- BURST, full stall: fifo_full high holds the FSM, owner and beat_cnt unchanged. No accept and no w_en are issued.
- BURST, end conditions: the burst ends on any of:
  - a beat with last[owner]=1;
  - a beat with beat_cnt==MAX_BURST-1;
  - req[owner]=0, which counts as release; no beat occurs that cycle.
- BURST, counting: a beat that does not end the burst increments beat_cnt.
- At burst end:
  - last_owner<=owner.
  - The arbiter re-arbitrates in the same cycle, using the updated pointer order that starts after the current owner.
  - If any req is high (including the same requester when it is the only one), load the new owner, set beat_cnt=0 and stay in BURST. Otherwise go to IDLE.
  - There are zero dead cycles between back-to-back bursts.
- Widths: beat_cnt is $clog2(MAX_BURST) bits, minimum 1. The owner index is compared modulo NUM_REQ, including when NUM_REQ is not a power of two.
- Simultaneous events: last and MAX_BURST occurring together give a single end. fifo_full and last together mean no beat, so the burst does not end.
- rst mid-burst: the in-flight beat is not written (w_en=0 in the reset cycle), and the next grant goes to requester 0 if it is requesting.
- Invariants: fifo_w_en is never high while fifo_full is high. accept is at most one-hot, and accept equals fifo_w_en broadcast onto the owner bit.

Decomposition:
- Package fifo_arb_pkg: state enum (IDLE, BURST) and a width helper for the index and counter.
- Sub-module rr_pick: purely combinational rotate-priority selector.
  - Inputs: req vector, last_owner.
  - Outputs: any_req, winner index.
  - Instantiated once; the FSM, counters and muxing stay in fifo_wr_arbiter.

Test Plan:
- Reset then req=4'b0001, last on the 2nd beat -> owner=0 one cycle after req; two accept[0] pulses on consecutive cycles; fifo_data = requester-0 beats (0xA1, 0xA2); then IDLE with busy=0.
- req=4'b1111 continuously, last never asserted, MAX_BURST=4 -> grant order 0,1,2,3,0; exactly 4 beats each; no idle cycle between bursts; 16 FIFO writes in 16 cycles.
- Requester 2 in BURST, fifo_full forced high for 3 cycles mid-burst -> fifo_w_en=0 and accept=0 for those cycles; beat_cnt holds; total of 4 writes preserved after full drops.
- Requester 1 drops req after 1 beat while req[3]=1 -> burst ends that cycle; owner=3 next cycle; no write in the drop cycle.
- rst asserted during requester 3's burst with req=4'b1010 -> no write in the reset cycle; IDLE after reset; next grant goes to owner=1 (pointer reset to 3, search starts at 0).
- Connected to the async FIFO (DEPTH=8) with a stalled reader -> exactly 8 beats accepted, then fifo_full blocks; data read out later in grant order with no loss or duplication.
